// File: rtl/calc_key_ctrl.sv
// On-screen keypad calculator: cursor navigation, entry buffer, A op B evaluation.
// Latency: key effects 1 edge after btn_ok; +/- result 1 edge after '=', '*' 16 edges; no backpressure.
module calc_key_ctrl #(
    parameter int BUF_LEN = 16
) (
    input  logic                   clk_in,
    input  logic                   sys_rst,
    input  logic                   btn_up,
    input  logic                   btn_down,
    input  logic                   btn_left,
    input  logic                   btn_right,
    input  logic                   btn_ok,
    output logic [3:0]             cursor_x,
    output logic [3:0]             cursor_y,
    output logic [8*BUF_LEN-1:0]   disp_str_flat,
    output logic [15:0]            result,
    output logic                   calc_done,
    output logic                   busy
);
    localparam int LW = $clog2(BUF_LEN + 1);

    typedef enum logic [2:0] {S_IDLE, S_ENTRY_A, S_ENTRY_B, S_EVAL, S_DONE} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

    state_t        state, state_nxt;
    op_t           op, key_op;
    logic [1:0]    cur_x, cur_y;
    logic [LW-1:0] len;
    logic [15:0]   a, b, prod, mcand, mplier;
    logic          b_has;
    logic [3:0]    cnt;
    logic [7:0]    key;
    logic [3:0]    dig;
    logic          is_dig, is_op, is_eq, is_clr;
    logic          room, do_clear, do_restart, app_dig, app_op, app_eq, eval_fin;

    assign cursor_x = {2'b00, cur_x};
    assign cursor_y = {2'b00, cur_y};

    // Key under the cursor as it stands before this cycle's move.
    always_comb begin
        key    = 8'h20;
        key_op = OP_ADD;
        is_dig = 1'b0;
        is_op  = 1'b0;
        is_eq  = 1'b0;
        is_clr = 1'b0;
        case ({cur_y, cur_x})
            4'd0:    begin key = "1"; is_dig = 1'b1; end
            4'd1:    begin key = "2"; is_dig = 1'b1; end
            4'd2:    begin key = "3"; is_dig = 1'b1; end
            4'd3:    begin key = "+"; is_op  = 1'b1; key_op = OP_ADD; end
            4'd4:    begin key = "4"; is_dig = 1'b1; end
            4'd5:    begin key = "5"; is_dig = 1'b1; end
            4'd6:    begin key = "6"; is_dig = 1'b1; end
            4'd7:    begin key = "-"; is_op  = 1'b1; key_op = OP_SUB; end
            4'd8:    begin key = "7"; is_dig = 1'b1; end
            4'd9:    begin key = "8"; is_dig = 1'b1; end
            4'd10:   begin key = "9"; is_dig = 1'b1; end
            4'd11:   begin key = "*"; is_op  = 1'b1; key_op = OP_MUL; end
            4'd12:   begin key = "C"; is_clr = 1'b1; end
            4'd13:   begin key = "0"; is_dig = 1'b1; end
            4'd14:   begin key = "="; is_eq  = 1'b1; end
            default: key = 8'h20;
        endcase
        dig = key[3:0];
    end

    // State register
    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (do_clear)                        state_nxt = S_IDLE;
        else if (do_restart)                 state_nxt = S_ENTRY_A;
        else if (app_dig && state == S_IDLE) state_nxt = S_ENTRY_A;
        else if (app_op)                     state_nxt = S_ENTRY_B;
        else if (app_eq)                     state_nxt = S_EVAL;
        else if (eval_fin)                   state_nxt = S_DONE;
    end

    // Output/action decode feeding the registered datapath
    always_comb begin
        room       = (len < LW'(BUF_LEN));
        do_clear   = btn_ok && is_clr;
        do_restart = btn_ok && is_dig && (state == S_DONE);
        app_dig    = btn_ok && is_dig && room &&
                     (state == S_IDLE || state == S_ENTRY_A || state == S_ENTRY_B);
        app_op     = btn_ok && is_op && room && (state == S_ENTRY_A);
        app_eq     = btn_ok && is_eq && room && (state == S_ENTRY_B) && b_has;
        eval_fin   = (state == S_EVAL) && (op != OP_MUL || cnt == 4'd15);
    end

    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            cur_x         <= '0;
            cur_y         <= '0;
            disp_str_flat <= {BUF_LEN{8'h20}};
            len           <= '0;
            a             <= '0;
            b             <= '0;
            b_has         <= 1'b0;
            op            <= OP_ADD;
            prod          <= '0;
            mcand         <= '0;
            mplier        <= '0;
            cnt           <= '0;
            result        <= '0;
            calc_done     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            if (btn_up)         cur_y <= cur_y - 2'd1;
            else if (btn_down)  cur_y <= cur_y + 2'd1;
            else if (btn_left)  cur_x <= cur_x - 2'd1;
            else if (btn_right) cur_x <= cur_x + 2'd1;

            busy      <= (state_nxt == S_EVAL);
            calc_done <= (state_nxt == S_DONE);

            if (do_clear) begin
                disp_str_flat <= {BUF_LEN{8'h20}};
                len           <= '0;
                a             <= '0;
                b             <= '0;
                b_has         <= 1'b0;
                cnt           <= '0;
                prod          <= '0;
                result        <= '0;
            end else if (do_restart) begin
                disp_str_flat <= {{(BUF_LEN-1){8'h20}}, key};
                len           <= LW'(1);
                a             <= {12'd0, dig};
                b             <= '0;
                b_has         <= 1'b0;
                result        <= '0;
            end else begin
                if (app_dig || app_op || app_eq) begin
                    disp_str_flat[8*len +: 8] <= key;
                    len                       <= len + LW'(1);
                end
                if (app_dig) begin
                    if (state == S_ENTRY_B) begin
                        b     <= b * 16'd10 + {12'd0, dig};
                        b_has <= 1'b1;
                    end else begin
                        a <= a * 16'd10 + {12'd0, dig};
                    end
                end
                if (app_op) op <= key_op;
                if (app_eq) begin
                    result <= '0;
                    prod   <= '0;
                    mcand  <= a;
                    mplier <= b;
                    cnt    <= '0;
                end
                // Multiplier consumes one bit of B per cycle; the last bit folds into the final load.
                if (state == S_EVAL) begin
                    if (eval_fin) begin
                        case (op)
                            OP_SUB:  result <= a - b;
                            OP_MUL:  result <= prod + (mplier[0] ? mcand : 16'd0);
                            default: result <= a + b;
                        endcase
                    end else begin
                        if (mplier[0]) prod <= prod + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 4'd1;
                    end
                end
            end
        end
    end
endmodule

// File: doc/calc_key_ctrl.md
CALC_KEY_CTRL -- requirements
Module: calc_key_ctrl

Interface
REQ-001 Parameter: BUF_LEN, default 16; character-buffer depth; fixed at 16, matching the 128-bit display string.
REQ-002 clk_in  input  1  system clock; all state updates on rising edge.
REQ-003 sys_rst  input  1  one clock; reset is asynchronous and active-high.
REQ-004 btn_up, btn_down, btn_left, btn_right  input  1 each  single-cycle cursor move pulses (pre-debounced).
REQ-005 btn_ok  input  1  single-cycle pulse; presses key under cursor.
REQ-006 cursor_x, cursor_y  output  4 each  cursor column/row, range 0..3.
REQ-007 disp_str_flat  output  128  entry string; char k at bits [k*8+7:k*8]; unused chars 0x20.
REQ-008 result  output  16  evaluation result, unsigned.
REQ-009 calc_done  output  1  result valid; high from evaluation completion until next clear/new entry.
REQ-010 busy  output  1  high while in EVAL.

Function
REQ-011 Key grid (row,col): r0 "1 2 3 +", r1 "4 5 6 -", r2 "7 8 9 *", r3 "C 0 = blank".
REQ-012 Navigation: one move per cycle, priority up>down>left>right; moves wrap modulo 4 (left at x=0 -> x=3; up at y=0 -> y=3); navigation allowed in every state.
REQ-013 btn_ok with a simultaneous move acts on the pre-move cursor position; move also applied.
REQ-014 FSM states: IDLE (empty), ENTRY_A, ENTRY_B, EVAL, DONE.
REQ-015 Digit key: appended at index len, len increments; operand = operand*10 + digit, truncated to 16 bits; IDLE->ENTRY_A; DONE clears buffer/result/calc_done and starts ENTRY_A with that digit.
REQ-016 Operator key: accepted only in ENTRY_A with >=1 digit; appends char, latches op, ENTRY_A->ENTRY_B; otherwise ignored.
REQ-017 '=' key: accepted only in ENTRY_B with >=1 B digit; appends '=', ENTRY_B->EVAL; otherwise ignored.
REQ-018 'C' key: from any state including EVAL, clears buffer to spaces, len, operands, result=0, calc_done=0, ->IDLE; cursor unchanged.
REQ-019 Blank key: no operation.
REQ-020 Buffer full (len=16): further character-appending keys ignored; state unchanged.
REQ-021 In EVAL, all keys except 'C' ignored.
REQ-022 '+'/'-': result = (A op B) mod 2^16 (subtraction wraps), loaded 1 edge after the edge entering EVAL; calc_done=1, busy=0, ->DONE.
REQ-023 '*': iterative shift-add over 16 cycles, product truncated to 16 bits; result loaded and calc_done=1 on the 16th edge after entering EVAL; busy high throughout.
REQ-024 result holds intermediate value 0 during EVAL; only the final value is visible.
REQ-025 All outputs are registered; key effects on disp_str_flat are visible 1 edge after the btn_ok edge.

Reset
REQ-026 On sys_rst assertion (async): cursor_x=0, cursor_y=0, disp_str_flat all 0x20, result=0, calc_done=0, busy=0, state IDLE, len=0.
REQ-027 Reset mid-EVAL aborts the computation; no calc_done pulse after release.
REQ-028 First active edge after sys_rst deassertion processes inputs normally.

Verification
REQ-029 Cursor wrap: from (0,0) btn_left -> x=3; btn_up -> y=3; up+right same cycle -> only y changes.
REQ-030 Key in "12+34=" -> disp "12+34=", calc_done 1 edge after EVAL entry, result=46.
REQ-031 "5-7=" -> result=65534; "300*300=" -> busy 16 cycles, result=24464, calc_done on 16th edge.
REQ-032 Illegal keys: "+" in IDLE, "1++", "1+=" -> extra operators/'=' ignored, disp "1+", no EVAL.
REQ-033 Buffer full: 17 digit presses -> disp 16 digits, 17th ignored; operand = truncated decimal mod 2^16.
REQ-034 Reset/clear: sys_rst or 'C' during '*' EVAL -> outputs at reset values, calc_done stays 0; then "2+2=" -> result=4.
